// File: rtl/seq_chk_pkg.sv
// seq_chk_pkg: state encoding and default sequence width shared with the pattern counter.
package seq_chk_pkg;

    localparam int SEQ_WIDTH = 6;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCKED = 2'd2,
        ST_UNUSED = 2'd3
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear; clear plus increment yields 1.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (clr)
            cnt <= W'(inc);
        else if (inc && cnt != '1)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/seq_checker.sv
// seq_checker: locks onto an incrementing counter stream, counts mismatches while locked,
// and drops lock after a run of consecutive mismatches.
module seq_checker
    import seq_chk_pkg::*;
#(
    parameter int WIDTH      = SEQ_WIDTH,
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_ERR = 4,
    parameter int ERRW       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             clr_err,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERRW-1:0]  err_count,
    output logic [1:0]       state
);

    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(UNLOCK_ERR + 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_exp;
    logic [GW-1:0]    r_good;
    logic [BW-1:0]    r_bad;
    logic             w_match;
    logic             w_err;
    logic [GW-1:0]    w_good_inc;
    logic [BW-1:0]    w_bad_inc;

    assign w_match    = in_data == r_exp;
    assign w_err      = in_valid && r_state == ST_LOCKED && !w_match;
    assign w_good_inc = r_good + 1'b1;
    assign w_bad_inc  = r_bad + 1'b1;
    assign state      = r_state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_SEARCH;
            r_exp     <= '0;
            r_good    <= '0;
            r_bad     <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            err_pulse <= w_err;
            case (r_state)
                ST_SEARCH: if (in_valid) begin
                    r_exp  <= in_data + 1'b1;
                    r_good <= GW'(1);
                    if (LOCK_CNT == 1) begin
                        r_state <= ST_LOCKED;
                        locked  <= 1'b1;
                        r_bad   <= '0;
                    end else
                        r_state <= ST_ACQ;
                end
                ST_ACQ: if (in_valid) begin
                    r_exp <= in_data + 1'b1;
                    if (w_match) begin
                        r_good <= w_good_inc;
                        if (w_good_inc == GW'(LOCK_CNT)) begin
                            r_state <= ST_LOCKED;
                            locked  <= 1'b1;
                            r_bad   <= '0;
                        end
                    end else
                        r_good <= GW'(1);
                end
                // No resync while locked: a corrupted word must not drag the expectation along.
                ST_LOCKED: if (in_valid) begin
                    r_exp <= r_exp + 1'b1;
                    r_bad <= w_match ? '0 : w_bad_inc;
                    if (!w_match && w_bad_inc == BW'(UNLOCK_ERR)) begin
                        r_state <= ST_SEARCH;
                        locked  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_SEARCH;
                    locked  <= 1'b0;
                end
            endcase
        end
    end

    sat_counter #(.W(ERRW)) u_err (
        .clk (clk),
        .rst (rst),
        .inc (w_err),
        .clr (clr_err),
        .cnt (err_count)
    );

endmodule

// File: doc/seq_checker.md
Name: seq_checker

Overview:
- Receive-side checker for the free-running 6-bit counter pattern used as the board test stream.
- Locks onto an incoming incrementing sequence and counts mismatches once locked.
- Drops lock after a run of consecutive errors.
- Outputs drive status LEDs and the error readout; the block sits at the far end of the link from the pattern counter.

Parameters:
- WIDTH, 6: data width of the incoming sequence.
- LOCK_CNT, 4: consecutive correct valid beats needed to declare lock (>=1).
- UNLOCK_ERR, 4: consecutive mismatching valid beats in LOCKED that force loss of lock (>=1).
- ERRW, 16: width of the saturating error counter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- in_valid  in  1  qualifies in_data for this cycle; gaps of any length allowed.
- in_data  in  WIDTH  received sequence word.
- clr_err  in  1  synchronous clear of err_count.
- locked  out  1  registered; 1 while in LOCKED.
- err_pulse  out  1  registered; one-cycle pulse per counted mismatch.
- err_count  out  ERRW  registered saturating mismatch count.
- state  out  2  registered FSM state for debug/LEDs.

Behaviour:
- Reset (rst=0, async): state=SEARCH(0), locked=0, err_pulse=0, err_count=0, exp=0, good_cnt=0, bad_run=0.
- All outputs are registered. A beat sampled at edge N is reflected in the outputs after edge N (1-cycle latency).
- in_valid=0: FSM, exp, good_cnt and bad_run hold. err_pulse=0.
- Arithmetic: exp is in_data+1 or exp+1 modulo 2^WIDTH. Wrap from 63 to 0 is a match.
- SEARCH(0): on valid, exp<=in_data+1 and good_cnt<=1. Go to LOCKED if LOCK_CNT==1, else go to ACQ.
- ACQ(1): on valid with in_data==exp, exp<=in_data+1 and good_cnt++. When good_cnt reaches LOCK_CNT, go to LOCKED with bad_run<=0.
- ACQ(1): on valid with a mismatch, reseed exp<=in_data+1, good_cnt<=1 and stay in ACQ. No errors are counted in SEARCH or ACQ.
- LOCKED(2): on valid with a match, exp<=exp+1 and bad_run<=0.
- LOCKED(2): on valid with a mismatch, exp<=exp+1 (no resync), err_pulse<=1, err_count++ (saturating at 2^ERRW-1), bad_run++.
- LOCKED(2): if the incremented bad_run equals UNLOCK_ERR, go to SEARCH and set locked<=0 on the same edge. That final error is still counted.
- Encoding 3 is unused. It returns to SEARCH on the next edge.
- clr_err: err_count<=0. If clr_err coincides with a counted error, err_count<=1. err_pulse is unaffected by clr_err.
- err_count is not cleared by loss of lock; only rst or clr_err clear it.
- Reset asserted mid-operation clears everything immediately, regardless of clk. Re-acquisition then takes LOCK_CNT valid beats.

Decomposition:
- Shared package seq_chk_pkg holds the state encoding constants (SEARCH=0, ACQ=1, LOCKED=2) and a default WIDTH constant of 6 shared with the pattern counter.
- One sub-module, sat_counter (parameter W; inputs inc, clr; output cnt; clr+inc yields 1), implements err_count.

Test Plan:
- Lock: valid stream 0,1,2,3,4 back-to-back -> locked=1 after the edge sampling 3, state=2, err_count=0.
- Wrap and gaps: locked, feed 61,62,63,0,1 with idle cycles between beats -> no err_pulse, locked stays 1.
- Single error: locked at 10, feed 11,40,13,14 -> one err_pulse on the beat after 40, err_count=1, locked stays 1, 13 and 14 accepted.
- Unlock: locked, feed 4 consecutive wrong values -> err_count=4, locked=0 after the 4th, state=0. A new stream 20..23 relocks after 23.
- Saturation and clear: ERRW=2, force 5 spread-out errors -> err_count=3. clr_err together with an error -> err_count=1. clr_err alone -> 0.
- Async reset: while locked with err_count=2, pull rst=0 between clock edges -> all outputs 0 immediately. After release, 4 good beats are needed to relock.
